// File: rtl/mul16_seq.sv
// ---------------------------------------------------------------------------
// mul16_seq -- sequential 16x16 unsigned shift-add multiplier
//
// One addition is done per clock. Each addition goes through a combinational
// 16-bit carry-skip adder, built from 4-bit ripple blocks with a skip path per
// block. An operation takes a fixed 17 cycles from the accepted start to done.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request a multiply; sampled only while ready=1
//   a      in  16   multiplicand, captured on an accepted start
//   b      in  16   multiplier, captured on an accepted start
//   ready  out  1   high in IDLE and DONE; a start is accepted
//   done   out  1   one-cycle pulse; p is valid from this cycle on
//   p      out 32   product {H,Q}; held until the next accepted start
//
// Build option:
//   MUL16_ZERO_SKIP_EN -- when defined, a start with a==0 or b==0 goes
//   straight to DONE, so done follows one cycle later.
// ---------------------------------------------------------------------------

// 4-bit ripple block of the carry-skip adder.
// prop: every bit propagates, so the block carry-out is the block carry-in.
// gen : the block carry-out for the case where the block does not fully
//       propagate. In that case the carry-out does not depend on ci, so the
//       inter-block carry chain never loops back through the ripple sums.
module csa_blk #(
    parameter int BLK_W = 4
) (
    input  logic [BLK_W-1:0] x,
    input  logic [BLK_W-1:0] y,
    input  logic             ci,
    output logic [BLK_W-1:0] s,
    output logic             prop,
    output logic             gen
);
    logic [BLK_W-1:0] pb;
    logic [BLK_W-1:0] gb;
    logic             c;
    logic             gg;

    assign pb   = x ^ y;
    assign gb   = x & y;
    assign prop = &pb;

    always_comb begin
        c  = ci;
        gg = 1'b0;
        s  = '0;
        for (int i = 0; i < BLK_W; i++) begin
            s[i] = pb[i] ^ c;
            c    = gb[i] | (pb[i] & c);
            gg   = gb[i] | (pb[i] & gg);
        end
        gen = gg;
    end
endmodule

// 16-bit carry-skip adder. Each block's carry-in comes from the skip chain.
module cs_add16 #(
    parameter int NUM_BLK = 4,
    parameter int BLK_W   = 4
) (
    input  logic [NUM_BLK*BLK_W-1:0] x,
    input  logic [NUM_BLK*BLK_W-1:0] y,
    input  logic                     ci,
    output logic [NUM_BLK*BLK_W-1:0] sum,
    output logic                     cout
);
    logic [NUM_BLK-1:0] bprop;
    logic [NUM_BLK-1:0] bgen;
    logic [NUM_BLK-1:0] bci;
    logic               c;

    // Skip chain: a fully propagating block passes its carry-in straight on.
    always_comb begin
        c   = ci;
        bci = '0;
        for (int k = 0; k < NUM_BLK; k++) begin
            bci[k] = c;
            c      = bprop[k] ? c : bgen[k];
        end
        cout = c;
    end

    for (genvar k = 0; k < NUM_BLK; k++) begin : g_blk
        csa_blk #(.BLK_W(BLK_W)) u_blk (
            .x    (x[k*BLK_W +: BLK_W]),
            .y    (y[k*BLK_W +: BLK_W]),
            .ci   (bci[k]),
            .s    (sum[k*BLK_W +: BLK_W]),
            .prop (bprop[k]),
            .gen  (bgen[k])
        );
    end
endmodule

module mul16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] p
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] m;
    logic [15:0] h;
    logic [15:0] q;
    logic [4:0]  cnt;

    logic [15:0] addend;
    logic [15:0] sum;
    logic        cout;
    logic        accept;

    // ready is registered and is high exactly in IDLE and DONE
    assign accept = start & ready;
    assign addend = q[0] ? m : 16'h0000;
    assign p      = {h, q};

    cs_add16 #(.NUM_BLK(4), .BLK_W(4)) u_add (
        .x    (h),
        .y    (addend),
        .ci   (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            m     <= '0;
            h     <= '0;
            q     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            ready <= 1'b1;
        end else if (accept) begin
            // Start from IDLE or back-to-back from DONE
            m   <= a;
            h   <= '0;
            q   <= b;
            cnt <= '0;
`ifdef MUL16_ZERO_SKIP_EN
            if (a == 16'h0000 || b == 16'h0000) begin
                q     <= '0;
                state <= S_DONE;
                done  <= 1'b1;
                ready <= 1'b1;
            end else begin
                state <= S_RUN;
                done  <= 1'b0;
                ready <= 1'b0;
            end
`else
            state <= S_RUN;
            done  <= 1'b0;
            ready <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    // The carry-out shifts into H[15]; the sum LSB becomes a
                    // product bit entering Q from the top.
                    h   <= {cout, sum[15:1]};
                    q   <= {sum[0], q[15:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                S_IDLE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_seq.sv
// ---------------------------------------------------------------------------
// tb_mul16_seq -- self-checking bench for mul16_seq.
// Expected products and latencies are pushed to a scoreboard when a start is
// driven; a monitor pops and compares them on every done pulse.
// ---------------------------------------------------------------------------
module tb_mul16_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [31:0] p;

`ifdef MUL16_ZERO_SKIP_EN
    localparam int LAT_Z = 1;
`else
    localparam int LAT_Z = 17;
`endif

    mul16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int          t0;
        int          lat;
    } sb_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    sb_t sbq[$];
    sb_t e;
    int  n_chk  = 0;
    int  n_pass = 0;
    int  n_done = 0;

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            n_done++;
            if (sbq.size() == 0) begin
                chk("spurious done", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("product", p, e.exp);
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp, input int lat);
        int k = 0;
        while (ready !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        if (ready !== 1'b1) chk("ready wait timeout", {31'b0, ready}, 32'd1);
        start = 1'b1;
        a     = x;
        b     = y;
        sbq.push_back('{exp, cyc, lat});
        step();
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        if (done !== 1'b1) chk("done timeout", {31'b0, done}, 32'd1);
    endtask

    initial begin
        vec_t        vt[8];
        int          d0;
        logic [15:0] x;
        logic [15:0] y;

        vt[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vt[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vt[2] = '{16'h8000, 16'h8000, 32'h40000000};
        vt[3] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
        vt[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
        vt[5] = '{16'h0100, 16'h0100, 32'h00010000};
        vt[6] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};
        vt[7] = '{16'h00FF, 16'h00FF, 32'h0000FE01};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) step();
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset p", p, 32'd0);
        rst_n = 1'b1;
        step();

        // 3*5 with ready observed low over all 16 RUN cycles
        issue(16'h0003, 16'h0005, 32'h0000000F, 17);
        for (int i = 0; i < 16; i++) begin
            chk("ready low in RUN", {31'b0, ready}, 32'd0);
            step();
        end
        chk("done at cycle 17", {31'b0, done}, 32'd1);
        repeat (3) step();
        chk("p held in IDLE", p, 32'h0000000F);
        chk("ready in IDLE", {31'b0, ready}, 32'd1);

        // Table of vectors
        for (int i = 0; i < 8; i++) begin
            issue(vt[i].a, vt[i].b, vt[i].exp, 17);
            wait_done();
            step();
        end

        // Back-to-back: second start held in the DONE cycle
        issue(16'h1234, 16'h0010, 32'h00012340, 17);
        wait_done();
        chk("ready in DONE", {31'b0, ready}, 32'd1);
        issue(16'h00FF, 16'h0100, 32'h0000FF00, 17);
        wait_done();
        step();

        // start pulses during RUN are ignored
        d0 = n_done;
        issue(16'h0101, 16'h0202, 32'h00020402, 17);
        repeat (2) step();
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1; a = 16'h0007; b = 16'h0009;
        step();
        start = 1'b0;
        wait_done();
        repeat (4) step();
        chk("single done", 32'(n_done - d0), 32'd1);

        // Reset at cycle 8 aborts the operation
        start = 1'b1; a = 16'h1234; b = 16'h5678;
        step();
        start = 1'b0;
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort p", p, 32'd0);
        chk("abort ready", {31'b0, ready}, 32'd1);
        step();
        rst_n = 1'b1;
        d0 = n_done;
        repeat (25) step();
        chk("no done after abort", 32'(n_done - d0), 32'd0);
        issue(16'h0007, 16'h0009, 32'h0000003F, 17);
        wait_done();
        step();

        // Zero operands
        issue(16'h0000, 16'hABCD, 32'h00000000, LAT_Z);
        wait_done();
        step();
        issue(16'h1234, 16'h0000, 32'h00000000, LAT_Z);
        wait_done();
        step();

        // Random nonzero operands against a reference multiply
        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom_range(1, 65535));
            y = 16'($urandom_range(1, 65535));
            issue(x, y, 32'(x) * 32'(y), 17);
            wait_done();
            step();
        end

        repeat (2) step();
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
